// File: rtl/ritc_train_controller.sv
// GLITCBUS-mapped RITC training sequencer (window 0x30-0x3F): TRAIN -> settle -> VCDL burst -> lock wait.
// Optional lock-wait timeout enabled by defining RITC_CTRL_TIMEOUT_EN.
module ritc_train_controller #(
`ifdef RITC_CTRL_TIMEOUT_EN
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
`endif
    parameter logic [15:0] SETTLE_DEFAULT = 16'd1000,
    parameter logic [7:0]  NPULSE_DEFAULT = 8'd16,
    parameter logic [7:0]  PERIOD_DEFAULT = 8'd8
) (
    input  logic        user_clk_i,
    input  logic        user_rst_n_i,
    input  logic        user_sel_i,
    input  logic [3:0]  user_addr_i,
    input  logic        user_wr_i,
    input  logic        user_rd_i,
    input  logic [31:0] user_dat_i,
    output logic [31:0] user_dat_o,
    input  logic [1:0]  lock_i,
    output logic [1:0]  train_o,
    output logic [1:0]  vcdl_o,
    output logic        busy_o,
    output logic        done_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SETTLE = 3'd1,
        S_PULSE  = 3'd2,
        S_LOCKW  = 3'd3,
        S_DONE   = 3'd4,
        S_ERROR  = 3'd5
    } state_t;

`ifdef RITC_CTRL_TIMEOUT_EN
    localparam int unsigned CW = 24;
`else
    localparam int unsigned CW = 16;
`endif

    state_t          state, next_state;
    logic [1:0]      mask_r, s_mask;
    logic [15:0]     settle_r, s_settle;
    logic [7:0]      npulse_r, s_npulse;
    logic [7:0]      period_r, s_period;
    logic [CW-1:0]   cyc;
    logic [7:0]      pcnt, npc, per_eff;
    logic [15:0]     run_cnt;
    logic            done_r, cfg_err, tmo_err;
    logic            pulse, settle_last;
    logic            wr_ctrl, start_req, abort_req, start_ok;
    logic            unused_ok;

    assign wr_ctrl   = user_sel_i & user_wr_i & (user_addr_i == 4'h0);
    assign start_req = wr_ctrl & user_dat_i[0];
    assign abort_req = wr_ctrl & user_dat_i[1];
    assign start_ok  = start_req & ~abort_req & (state == S_IDLE);
    assign per_eff   = (s_period == 8'd0) ? 8'd1 : s_period;
    // A SETTLE value of 0 still yields one SETTLE cycle.
    assign settle_last = ({1'b0, cyc[15:0]} + 17'd1) >= {1'b0, s_settle};
    assign unused_ok = &{1'b0, user_rd_i, user_dat_i[31:16]};

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) state <= S_IDLE;
        else               state <= next_state;
    end

    always_comb begin
        next_state = state;
        train_o    = '0;
        vcdl_o     = '0;
        busy_o     = 1'b0;
        pulse      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_ok && user_dat_i[3:2] != 2'b00) next_state = S_SETTLE;
            end
            S_SETTLE: begin
                busy_o  = 1'b1;
                train_o = s_mask;
                if (settle_last) next_state = (s_npulse == 8'd0) ? S_LOCKW : S_PULSE;
            end
            S_PULSE: begin
                busy_o  = 1'b1;
                train_o = s_mask;
                if (pcnt == 8'd0) begin
                    pulse  = 1'b1;
                    vcdl_o = s_mask;
                    if (({1'b0, npc} + 9'd1) >= {1'b0, s_npulse}) next_state = S_LOCKW;
                end
            end
            S_LOCKW: begin
                busy_o  = 1'b1;
                train_o = s_mask;
                if ((lock_i & s_mask) == s_mask) next_state = S_DONE;
`ifdef RITC_CTRL_TIMEOUT_EN
                else if (cyc == TIMEOUT_CYCLES - 24'd1) next_state = S_ERROR;
`endif
            end
            S_DONE:  next_state = S_IDLE;
            S_ERROR: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        if (abort_req) next_state = S_IDLE;
    end

    // Counters restart on every state change so each state sees a fresh count.
    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            cyc  <= '0;
            pcnt <= '0;
            npc  <= '0;
        end else if (next_state != state) begin
            cyc  <= '0;
            pcnt <= '0;
            npc  <= '0;
        end else begin
            cyc  <= cyc + 1'b1;
            pcnt <= (pcnt >= per_eff - 8'd1) ? 8'd0 : pcnt + 8'd1;
            npc  <= npc + {7'd0, pulse};
        end
    end

    always_ff @(posedge user_clk_i or negedge user_rst_n_i) begin
        if (!user_rst_n_i) begin
            mask_r   <= 2'b11;
            settle_r <= SETTLE_DEFAULT;
            npulse_r <= NPULSE_DEFAULT;
            period_r <= PERIOD_DEFAULT;
            s_mask   <= 2'b11;
            s_settle <= SETTLE_DEFAULT;
            s_npulse <= NPULSE_DEFAULT;
            s_period <= PERIOD_DEFAULT;
            run_cnt  <= '0;
            done_r   <= 1'b0;
            cfg_err  <= 1'b0;
            tmo_err  <= 1'b0;
        end else begin
            if (user_sel_i && user_wr_i) begin
                case (user_addr_i)
                    4'h0: mask_r <= user_dat_i[3:2];
                    4'h2: settle_r <= user_dat_i[15:0];
                    4'h3: begin
                        npulse_r <= user_dat_i[7:0];
                        period_r <= user_dat_i[15:8];
                    end
                    default: ;
                endcase
            end
            if (start_ok) begin
                s_mask   <= user_dat_i[3:2];
                s_settle <= settle_r;
                s_npulse <= npulse_r;
                s_period <= period_r;
                done_r   <= 1'b0;
                tmo_err  <= 1'b0;
                cfg_err  <= (user_dat_i[3:2] == 2'b00);
            end
            if (state == S_LOCKW && next_state == S_DONE) begin
                done_r  <= 1'b1;
                run_cnt <= run_cnt + 16'd1;
            end
            if (next_state == S_ERROR) tmo_err <= 1'b1;
            if (abort_req) done_r <= 1'b0;
        end
    end

    assign done_o = done_r;

    always_comb begin
        user_dat_o = '0;
        case (user_addr_i)
            4'h0: user_dat_o[3:2] = mask_r;
            4'h1: begin
                user_dat_o[2:0]   = state;
                user_dat_o[3]     = busy_o;
                user_dat_o[4]     = done_r;
`ifdef RITC_CTRL_TIMEOUT_EN
                user_dat_o[5]     = tmo_err;
`endif
                user_dat_o[6]     = cfg_err;
                user_dat_o[9:8]   = lock_i;
                user_dat_o[31:16] = run_cnt;
            end
            4'h2: user_dat_o[15:0] = settle_r;
            4'h3: user_dat_o[15:0] = {period_r, npulse_r};
            default: user_dat_o = '0;
        endcase
    end

`ifndef RITC_CTRL_TIMEOUT_EN
    logic unused_tmo;
    assign unused_tmo = tmo_err;
`endif

endmodule

// File: tb/tb_ritc_train_controller.sv
// Directed self-checking bench for ritc_train_controller; timeout scenario runs only with RITC_CTRL_TIMEOUT_EN.
module tb_ritc_train_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        sel = 1'b0;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [3:0]  addr = 4'h1;
    logic [31:0] dat = '0;
    logic [1:0]  lock = 2'b00;
    logic [31:0] dout;
    logic [1:0]  train, vcdl;
    logic        busy, done;
    int          n_checks = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    ritc_train_controller #(
`ifdef RITC_CTRL_TIMEOUT_EN
        .TIMEOUT_CYCLES(24'd100),
`endif
        .SETTLE_DEFAULT(16'd1000),
        .NPULSE_DEFAULT(8'd16),
        .PERIOD_DEFAULT(8'd8)
    ) dut (
        .user_clk_i(clk), .user_rst_n_i(rst_n), .user_sel_i(sel), .user_addr_i(addr),
        .user_wr_i(wr), .user_rd_i(rd), .user_dat_i(dat), .user_dat_o(dout),
        .lock_i(lock), .train_o(train), .vcdl_o(vcdl), .busy_o(busy), .done_o(done)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One-cycle register write; leaves addr parked on STATUS so dout[2:0] is the state.
    task automatic wreg(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1'b1; wr = 1'b1; addr = a; dat = d;
        @(negedge clk);
        sel = 1'b0; wr = 1'b0; addr = 4'h1; dat = '0;
        #1;
    endtask

    task automatic test_reset();
        logic [31:0] exp_rd [5];
        logic [3:0]  rd_addr [5];
        rd_addr = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h7};
        exp_rd  = '{32'h0000_000C, 32'h0, 32'h0000_03E8, 32'h0000_0810, 32'h0};
        repeat (2) @(negedge clk);
        n_checks++;
        if ({train, vcdl, busy, done} !== 6'b0) begin
            $display("FAIL reset_outputs: got %b expected 000000", {train, vcdl, busy, done}); n_fail++;
        end
        rst_n = 1'b1;
        #1;
        wreg(4'h5, 32'hFFFF_FFFF);
        for (int i = 0; i < 5; i++) begin
            addr = rd_addr[i];
            #1;
            n_checks++;
            if (dout !== exp_rd[i]) begin
                $display("FAIL reset_read%0h: got %h expected %h", rd_addr[i], dout, exp_rd[i]); n_fail++;
            end
        end
        addr = 4'h1;
        #1;
    endtask

    task automatic test_sequence();
        wreg(4'h2, 32'd4);
        wreg(4'h3, 32'h0000_0503);
        lock = 2'b11;
        wreg(4'h0, 32'hD);
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({dout[2:0], train, vcdl, busy} !== {3'd1, 2'b11, 2'b00, 1'b1}) begin
                $display("FAIL settle_c%0d: got %b expected 00111001", i, {dout[2:0], train, vcdl, busy}); n_fail++;
            end
            tick();
        end
        for (int p = 0; p < 11; p++) begin
            n_checks++;
            if ({dout[2:0], train, vcdl} !== {3'd2, 2'b11, (p % 5 == 0) ? 2'b11 : 2'b00}) begin
                $display("FAIL pulse_c%0d: got %b vcdl_exp %0d", p, {dout[2:0], train, vcdl}, (p % 5 == 0) ? 3 : 0); n_fail++;
            end
            tick();
        end
        n_checks++;
        if (dout[2:0] !== 3'd3) begin $display("FAIL seq_lockw: got %0d expected 3", dout[2:0]); n_fail++; end
        tick();
        n_checks++;
        if ({dout[2:0], train, busy, done} !== {3'd4, 2'b00, 1'b0, 1'b1}) begin
            $display("FAIL seq_done: got %b expected 1000001", {dout[2:0], train, busy, done}); n_fail++;
        end
        tick();
        n_checks++;
        if ({dout[31:16], dout[4], dout[2:0], done} !== {16'd1, 1'b1, 3'd0, 1'b1}) begin
            $display("FAIL seq_status: got run=%0d done=%b st=%0d expected run=1 done=1 st=0", dout[31:16], done, dout[2:0]); n_fail++;
        end
    endtask

    task automatic test_partial_lock();
        int pulses = 0;
        lock = 2'b10;
        wreg(4'h0, 32'h5);
        for (int i = 0; i < 100 && dout[2:0] != 3'd3; i++) begin
            n_checks++;
            if ({train, vcdl[1]} !== 3'b010) begin
                $display("FAIL mask1_pre_c%0d: got train=%b vcdl=%b expected train=01 vcdl[1]=0", i, train, vcdl); n_fail++;
            end
            if (vcdl[0]) pulses++;
            tick();
        end
        n_checks++;
        if ({dout[2:0], pulses[3:0]} !== {3'd3, 4'd3}) begin
            $display("FAIL mask1_reach: got st=%0d pulses=%0d expected st=3 pulses=3", dout[2:0], pulses); n_fail++;
        end
        for (int i = 0; i < 50; i++) begin
            tick();
            n_checks++;
            if ({dout[2:0], train, vcdl} !== {3'd3, 2'b01, 2'b00}) begin
                $display("FAIL mask1_hold_c%0d: got %b expected 0110100", i, {dout[2:0], train, vcdl}); n_fail++;
            end
        end
        lock = 2'b01;
        tick();
        n_checks++;
        if (dout[2:0] !== 3'd4) begin $display("FAIL mask1_done: got %0d expected 4", dout[2:0]); n_fail++; end
        tick();
        n_checks++;
        if ({dout[2:0], dout[31:16]} !== {3'd0, 16'd2}) begin
            $display("FAIL mask1_end: got st=%0d run=%0d expected st=0 run=2", dout[2:0], dout[31:16]); n_fail++;
        end
    endtask

    task automatic test_abort();
        lock = 2'b00;
        wreg(4'h0, 32'hD);
        for (int i = 0; i < 20 && dout[2:0] != 3'd2; i++) tick();
        n_checks++;
        if (dout[2:0] !== 3'd2) begin $display("FAIL abort_reach_pulse: got %0d expected 2", dout[2:0]); n_fail++; end
        wreg(4'h0, 32'hE);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({dout[2:0], train, vcdl, busy, done} !== 9'b0) begin
                $display("FAIL abort_c%0d: got %b expected 000000000", i, {dout[2:0], train, vcdl, busy, done}); n_fail++;
            end
            tick();
        end
    endtask

    task automatic test_cfg_err();
        wreg(4'h0, 32'h1);
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if ({dout[6], dout[3], dout[2:0], train} !== {1'b1, 1'b0, 3'd0, 2'b00}) begin
                $display("FAIL cfg_err_c%0d: got cfg=%b busy=%b st=%0d train=%b expected 1 0 0 00", i, dout[6], dout[3], dout[2:0], train); n_fail++;
            end
            tick();
        end
        wreg(4'h0, 32'hF);
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({dout[2:0], train, busy} !== 6'b0) begin
                $display("FAIL start_abort_c%0d: got %b expected 000000", i, {dout[2:0], train, busy}); n_fail++;
            end
            tick();
        end
        addr = 4'h0;
        #1;
        n_checks++;
        if (dout !== 32'h0000_000C) begin $display("FAIL ctrl_readback: got %h expected 0000000c", dout); n_fail++; end
        addr = 4'h1;
        #1;
    endtask

    task automatic test_zero_cfg();
        logic [2:0] exp_st [4];
        logic [1:0] exp_vc [4];
        wreg(4'h2, 32'd0);
        wreg(4'h3, 32'd0);
        lock = 2'b11;
        wreg(4'h0, 32'hD);
        exp_st = '{3'd1, 3'd3, 3'd4, 3'd0};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (dout[2:0] !== exp_st[i]) begin
                $display("FAIL zero_cfg_c%0d: got st=%0d expected %0d", i, dout[2:0], exp_st[i]); n_fail++;
            end
            tick();
        end
        n_checks++;
        if ({dout[31:16], dout[6]} !== {16'd3, 1'b0}) begin
            $display("FAIL zero_cfg_status: got run=%0d cfg=%b expected run=3 cfg=0", dout[31:16], dout[6]); n_fail++;
        end
        wreg(4'h3, 32'h0000_0002);
        wreg(4'h0, 32'hD);
        exp_st = '{3'd1, 3'd2, 3'd2, 3'd3};
        exp_vc = '{2'b00, 2'b11, 2'b11, 2'b00};
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if ({dout[2:0], vcdl} !== {exp_st[i], exp_vc[i]}) begin
                $display("FAIL period0_c%0d: got st=%0d vcdl=%b expected st=%0d vcdl=%b", i, dout[2:0], vcdl, exp_st[i], exp_vc[i]); n_fail++;
            end
            tick();
        end
        tick();
    endtask

    task automatic test_async_reset();
        wreg(4'h2, 32'd4);
        wreg(4'h3, 32'h0000_0503);
        wreg(4'h0, 32'hD);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({dout[2:0], train, vcdl, busy, done} !== 9'b0) begin
            $display("FAIL areset_outputs: got %b expected 000000000", {dout[2:0], train, vcdl, busy, done}); n_fail++;
        end
        n_checks++;
        if (dout[31:16] !== 16'd0) begin $display("FAIL areset_run: got %0d expected 0", dout[31:16]); n_fail++; end
        addr = 4'h2;
        #1;
        n_checks++;
        if (dout !== 32'h0000_03E8) begin $display("FAIL areset_settle: got %h expected 000003e8", dout); n_fail++; end
        addr = 4'h1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

`ifdef RITC_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int n = 0;
        wreg(4'h2, 32'd0);
        wreg(4'h3, 32'd0);
        lock = 2'b00;
        wreg(4'h0, 32'hD);
        tick();
        while (dout[2:0] == 3'd3 && n < 200) begin
            n++;
            tick();
        end
        n_checks++;
        if (n !== 100) begin $display("FAIL timeout_cycles: got %0d expected 100", n); n_fail++; end
        n_checks++;
        if ({dout[2:0], dout[5], train} !== {3'd5, 1'b1, 2'b00}) begin
            $display("FAIL timeout_error: got st=%0d tmo=%b train=%b expected 5 1 00", dout[2:0], dout[5], train); n_fail++;
        end
        tick();
        n_checks++;
        if ({dout[2:0], dout[5]} !== {3'd0, 1'b1}) begin
            $display("FAIL timeout_idle: got st=%0d tmo=%b expected 0 1", dout[2:0], dout[5]); n_fail++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_sequence();
        test_partial_lock();
        test_abort();
        test_cfg_err();
        test_zero_cfg();
        test_async_reset();
`ifdef RITC_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
